// File: rtl/btn_debounce_pulse_if.sv
// Pushbutton conditioning bundle: raw pins and repeat enables in,
// debounced levels and strobes out.
interface btn_debounce_pulse_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_n;
    logic [N_BTN-1:0] repeat_en;
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] release_stb;
    logic [N_BTN-1:0] evt;
    logic             any_press;

    modport master (
        input  btn_n,
        input  repeat_en,
        output pressed,
        output press,
        output release_stb,
        output evt,
        output any_press
    );

    modport slave (
        output btn_n,
        output repeat_en,
        input  pressed,
        input  press,
        input  release_stb,
        input  evt,
        input  any_press
    );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Synchronise, debounce and edge-detect active-low pushbuttons, with
// per-button auto-repeat event generation.
module btn_debounce_pulse #(
    parameter int N_BTN        = 5,
    parameter int CNT_W        = 20,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input logic FiftyM_clk,
    input logic rst,
    btn_debounce_pulse_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        REPEAT
    } rstate_t;

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_MAX = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [N_BTN-1:0] s1_q, s1_d;
    logic [N_BTN-1:0] s2_q, s2_d;
    logic [N_BTN-1:0] raw_p;
    logic [N_BTN-1:0] pressed_q, pressed_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] rel_q, rel_d;
    logic [N_BTN-1:0] evt_q, evt_d;
    logic [N_BTN-1:0] rep_d;
    logic             any_q, any_d;
    logic [CNT_W-1:0] db_cnt_q [N_BTN];
    logic [CNT_W-1:0] db_cnt_d [N_BTN];
    logic [CNT_W-1:0] rcnt_q   [N_BTN];
    logic [CNT_W-1:0] rcnt_d   [N_BTN];
    rstate_t          st_q     [N_BTN];
    rstate_t          st_d     [N_BTN];

    always_comb begin
        s1_d  = bus.btn_n;
        s2_d  = s1_q;
        raw_p = ~s2_q;
        pressed_d = pressed_q;
        for (int i = 0; i < N_BTN; i++) begin
            db_cnt_d[i] = '0;
            if (raw_p[i] != pressed_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    pressed_d[i] = raw_p[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + ONE;
                end
            end
        end
        press_d = pressed_d & ~pressed_q;
        rel_d   = ~pressed_d & pressed_q;
    end

    // Release wins over any pending repeat so the release cycle never
    // carries a repeat strobe.
    always_comb begin
        rep_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            st_d[i]   = st_q[i];
            rcnt_d[i] = rcnt_q[i];
            if (rel_d[i]) begin
                st_d[i]   = IDLE;
                rcnt_d[i] = '0;
            end else begin
                unique case (st_q[i])
                    IDLE: begin
                        if (press_d[i]) begin
                            st_d[i]   = WAIT_FIRST;
                            rcnt_d[i] = '0;
                        end
                    end
                    WAIT_FIRST: begin
                        if (rcnt_q[i] == RD_MAX) begin
                            if (bus.repeat_en[i]) begin
                                rep_d[i]  = 1'b1;
                                rcnt_d[i] = '0;
                                st_d[i]   = REPEAT;
                            end
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + ONE;
                        end
                    end
                    REPEAT: begin
                        if (rcnt_q[i] == RR_MAX) begin
                            if (bus.repeat_en[i]) begin
                                rep_d[i]  = 1'b1;
                                rcnt_d[i] = '0;
                            end
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + ONE;
                        end
                    end
                    default: begin
                        st_d[i]   = IDLE;
                        rcnt_d[i] = '0;
                    end
                endcase
            end
        end
        evt_d = press_d | rep_d;
        any_d = |press_d;
    end

    always_ff @(posedge FiftyM_clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= '1;
            s2_q      <= '1;
            pressed_q <= '0;
            press_q   <= '0;
            rel_q     <= '0;
            evt_q     <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i] <= '0;
                rcnt_q[i]   <= '0;
                st_q[i]     <= IDLE;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            evt_q     <= evt_d;
            any_q     <= any_d;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                rcnt_q[i]   <= rcnt_d[i];
                st_q[i]     <= st_d[i];
            end
        end
    end

    assign bus.pressed     = pressed_q;
    assign bus.press       = press_q;
    assign bus.release_stb = rel_q;
    assign bus.evt         = evt_q;
    assign bus.any_press   = any_q;
endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with short debounce/repeat
// thresholds (4 / 10 / 3).
module tb_btn_debounce_pulse;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    btn_debounce_pulse_if #(.N_BTN(N)) bus ();

    btn_debounce_pulse #(
        .N_BTN       (N),
        .CNT_W       (8),
        .DEBOUNCE_CYC(4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE (3)
    ) dut (
        .FiftyM_clk(clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs,
                       input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] e;
        bus.btn_n     = 5'b00000;
        bus.repeat_en = 5'b00000;

        // Reset with all buttons held down
        tick();
        tick();
        chk("rst_pressed", bus.pressed, 5'b0);
        chk("rst_press", bus.press, 5'b0);
        chk("rst_release", bus.release_stb, 5'b0);
        chk("rst_evt", bus.evt, 5'b0);
        chk("rst_any", {4'b0, bus.any_press}, 5'b0);

        rst = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            e = (t == 6) ? 5'b11111 : 5'b0;
            chk($sformatf("boot_press t=%0d", t), bus.press, e);
            chk($sformatf("boot_any t=%0d", t), {4'b0, bus.any_press},
                (t == 6) ? 5'b1 : 5'b0);
            chk($sformatf("boot_pressed t=%0d", t), bus.pressed,
                (t >= 6) ? 5'b11111 : 5'b0);
        end

        bus.btn_n = 5'b11111;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk($sformatf("boot_rel t=%0d", t), bus.release_stb,
                (t == 6) ? 5'b11111 : 5'b0);
            chk($sformatf("boot_rel_pressed t=%0d", t), bus.pressed,
                (t < 6) ? 5'b11111 : 5'b0);
            chk($sformatf("boot_rel_evt t=%0d", t), bus.evt, 5'b0);
        end

        // Glitch on up: low 3, high 2, low 3
        for (int t = 0; t < 16; t++) begin
            bus.btn_n = (t < 3 || (t >= 5 && t < 8)) ? 5'b11110 : 5'b11111;
            tick();
            chk($sformatf("glitch_pressed t=%0d", t), bus.pressed, 5'b0);
            chk($sformatf("glitch_press t=%0d", t), bus.press, 5'b0);
            chk($sformatf("glitch_evt t=%0d", t), bus.evt, 5'b0);
        end

        // Clean star press, 20 cycles
        bus.btn_n = 5'b01111;
        for (int t = 1; t <= 20; t++) begin
            tick();
            e = (t == 6) ? 5'b10000 : 5'b0;
            chk($sformatf("star_press t=%0d", t), bus.press, e);
            chk($sformatf("star_evt t=%0d", t), bus.evt, e);
            chk($sformatf("star_any t=%0d", t), {4'b0, bus.any_press},
                (t == 6) ? 5'b1 : 5'b0);
            chk($sformatf("star_pressed t=%0d", t), bus.pressed,
                (t >= 6) ? 5'b10000 : 5'b0);
        end
        bus.btn_n = 5'b11111;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk($sformatf("star_rel t=%0d", t), bus.release_stb,
                (t == 6) ? 5'b10000 : 5'b0);
            chk($sformatf("star_rel_evt t=%0d", t), bus.evt, 5'b0);
        end

        // Auto-repeat on left, held 40 cycles
        bus.repeat_en = 5'b00010;
        bus.btn_n     = 5'b11101;
        for (int t = 1; t <= 50; t++) begin
            if (t == 41) bus.btn_n = 5'b11111;
            tick();
            e = (t == 6 || (t >= 16 && t < 46 && (t - 16) % 3 == 0))
                ? 5'b00010 : 5'b0;
            chk($sformatf("rep_evt t=%0d", t), bus.evt, e);
            chk($sformatf("rep_rel t=%0d", t), bus.release_stb,
                (t == 46) ? 5'b00010 : 5'b0);
            chk($sformatf("rep_pressed t=%0d", t), bus.pressed,
                (t >= 6 && t < 46) ? 5'b00010 : 5'b0);
        end
        bus.repeat_en = 5'b00000;

        // Repeat gating on down, enabled at P+15
        bus.btn_n = 5'b11011;
        for (int t = 1; t <= 26; t++) begin
            if (t == 21) bus.repeat_en = 5'b00100;
            tick();
            e = (t == 6 || t == 21 || t == 24) ? 5'b00100 : 5'b0;
            chk($sformatf("gate_evt t=%0d", t), bus.evt, e);
        end
        chk("gate_pressed", bus.pressed, 5'b00100);

        // Async reset while down is in REPEAT
        #2 rst = 1'b0;
        #1;
        chk("areset_pressed", bus.pressed, 5'b0);
        chk("areset_release", bus.release_stb, 5'b0);
        chk("areset_evt", bus.evt, 5'b0);
        for (int t = 1; t <= 2; t++) begin
            tick();
            chk($sformatf("areset_hold_pressed t=%0d", t), bus.pressed, 5'b0);
            chk($sformatf("areset_hold_rel t=%0d", t), bus.release_stb, 5'b0);
        end
        #2 rst = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk($sformatf("repress_press t=%0d", t), bus.press,
                (t == 6) ? 5'b00100 : 5'b0);
            chk($sformatf("repress_pressed t=%0d", t), bus.pressed,
                (t >= 6) ? 5'b00100 : 5'b0);
            chk($sformatf("repress_rel t=%0d", t), bus.release_stb, 5'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
